// File: rtl/ex_stage.sv
// MIPS execute stage: EX register, ALU, HI/LO, 33-cycle restoring divider; optional mult/multu via `EX_MULT_EN.
// Outputs are combinational from the EX register; stallreq_for_ex holds upstream while the divider works.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 164,
  parameter int EX_TO_MEM_WD = 81,
  parameter int EX_TO_RF_WD  = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex,
  output logic                    ex_is_load
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [ID_TO_EX_WD-1:0] ex_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_reg <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_reg <= '0;
    end else if (!stall[2]) begin
      ex_reg <= id_to_ex_bus;
    end
  end

  logic [4:0]  mem_op;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] data1;
  logic [31:0] data2;

  assign mem_op       = ex_reg[163:159];
  assign pc           = ex_reg[158:127];
  assign inst         = ex_reg[126:95];
  assign alu_op       = ex_reg[94:83];
  assign sel_alu_src1 = ex_reg[82:80];
  assign sel_alu_src2 = ex_reg[79:76];
  assign data_ram_en  = ex_reg[75];
  assign data_ram_wen = ex_reg[74:71];
  assign rf_we        = ex_reg[70];
  assign rf_waddr     = ex_reg[69:65];
  assign sel_rf_res   = ex_reg[64];
  assign data1        = ex_reg[63:32];
  assign data2        = ex_reg[31:0];

  logic leave;
  assign leave = !stall[2];

  logic special;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_div, is_divu, is_div_op;
  logic is_mult, is_multu;

  assign special   = (inst[31:26] == 6'b000000);
  assign is_mfhi   = special && (inst[5:0] == 6'b010000);
  assign is_mthi   = special && (inst[5:0] == 6'b010001);
  assign is_mflo   = special && (inst[5:0] == 6'b010010);
  assign is_mtlo   = special && (inst[5:0] == 6'b010011);
  assign is_mult   = special && (inst[5:0] == 6'b011000);
  assign is_multu  = special && (inst[5:0] == 6'b011001);
  assign is_div    = special && (inst[5:0] == 6'b011010);
  assign is_divu   = special && (inst[5:0] == 6'b011011);
  assign is_div_op = is_div || is_divu;

  // Operand selection
  logic [31:0] src1, src2;
  logic [4:0]  shamt;

  assign src1 = ({32{sel_alu_src1[0]}} & data1)
              | ({32{sel_alu_src1[1]}} & pc)
              | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_alu_src2[0]}} & data2)
              | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_alu_src2[2]}} & 32'd8)
              | ({32{sel_alu_src2[3]}} & {16'b0, inst[15:0]});
  assign shamt = src1[4:0];

  logic [31:0] sra_res;
  logic [31:0] alu_result;
  assign sra_res = $unsigned($signed(src2) >>> shamt);

  always_comb begin
    alu_result = 32'b0;
    if (alu_op[11]) alu_result = alu_result | (src1 + src2);
    if (alu_op[10]) alu_result = alu_result | (src1 - src2);
    if (alu_op[9])  alu_result = alu_result | {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[8])  alu_result = alu_result | {31'b0, src1 < src2};
    if (alu_op[7])  alu_result = alu_result | (src1 & src2);
    if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[5])  alu_result = alu_result | (src1 | src2);
    if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[3])  alu_result = alu_result | (src2 << shamt);
    if (alu_op[2])  alu_result = alu_result | (src2 >> shamt);
    if (alu_op[1])  alu_result = alu_result | sra_res;
    if (alu_op[0])  alu_result = alu_result | {src2[15:0], 16'b0};
  end

  // Divider: magnitudes are divided, signs applied on the way out
  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] rem_q;
  logic [31:0] dvs;
  logic        neg_q, neg_r;
  logic [31:0] abs_a, abs_b;
  logic [32:0] part;
  logic [31:0] quot, remd;

  assign abs_a = (is_div && data1[31]) ? (32'b0 - data1) : data1;
  assign abs_b = (is_div && data2[31]) ? (32'b0 - data2) : data2;
  assign part  = rem_q[63:31];
  assign quot  = neg_q ? (32'b0 - rem_q[31:0])  : rem_q[31:0];
  assign remd  = neg_r ? (32'b0 - rem_q[63:32]) : rem_q[63:32];

  always_ff @(posedge clk) begin
    if (rst || flush) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    case (state)
      IDLE: begin
        if (is_div_op) begin
          state_nxt       = BUSY;
          stallreq_for_ex = 1'b1;
        end
      end
      BUSY: begin
        stallreq_for_ex = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        if (leave) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 5'd0;
      rem_q <= 64'b0;
      dvs   <= 32'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && is_div_op) begin
      cnt   <= 5'd0;
      rem_q <= {32'b0, abs_a};
      dvs   <= abs_b;
      neg_q <= is_div && (data1[31] ^ data2[31]);
      neg_r <= is_div && data1[31];
    end else if (state == BUSY) begin
      cnt <= cnt + 5'd1;
      if (part >= {1'b0, dvs}) rem_q <= {part[31:0] - dvs, rem_q[30:0], 1'b1};
      else                     rem_q <= {rem_q[62:0], 1'b0};
    end
  end

  logic [31:0] hi, lo;
`ifdef EX_MULT_EN
  logic [63:0] product;
  assign product = is_mult ? ({{32{data1[31]}}, data1} * {{32{data2[31]}}, data2})
                           : ({32'b0, data1} * {32'b0, data2});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'b0;
      lo <= 32'b0;
    end else if (!flush && leave) begin
      if (state == DONE) begin
        lo <= quot;
        hi <= remd;
      end else begin
        if (is_mthi) hi <= data1;
        if (is_mtlo) lo <= data1;
`ifdef EX_MULT_EN
        if (is_mult || is_multu) {hi, lo} <= product;
`endif
      end
    end
  end

  logic [31:0] ex_result;
  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_result);

  assign ex_to_mem_bus   = {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res,
                            rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = {4{|data_ram_wen}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = data2;
  assign ex_is_load      = sel_rf_res;

  logic unused_bits;
`ifdef EX_MULT_EN
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
`else
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], is_mult, is_multu};
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, memory request, divider timing/results, flush, bubble, HI/LO forwarding.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [5:0]   stall;
  logic [5:0]   stall_drv;
  logic [163:0] id_to_ex_bus;
  logic [80:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;
  logic         ex_is_load;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex),
    .ex_is_load      (ex_is_load)
  );

  // Pipeline control model: a divider stall request freezes stages 0..3
  assign stall = stallreq_for_ex ? 6'b001111 : stall_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [11:0] OP_ADD = 12'h800;

  function automatic logic [163:0] mk(input logic [31:0] inst, input logic [11:0] alu,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ram_en, input logic [3:0] ram_wen,
                                      input logic we, input logic [4:0] wa, input logic sel_res,
                                      input logic [31:0] pc, input logic [31:0] d1,
                                      input logic [31:0] d2);
    return {5'd0, pc, inst, alu, s1, s2, ram_en, ram_wen, we, wa, sel_res, d1, d2};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] func, input logic [4:0] rd);
    return {6'b0, 5'd1, 5'd2, rd, 5'd0, func};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_to_ex_bus = mk(32'hAC22_0004, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b1, 5'd9, 1'b1,
                      32'h0040_0000, 32'h1, 32'h2);
    step();
    step();
    n_checks++;
    if (ex_to_mem_bus !== 81'b0) begin n_fail++; $display("FAIL reset_mem_bus got=%h want=0", ex_to_mem_bus); end
    n_checks++;
    if (ex_to_rf_bus !== 38'b0) begin n_fail++; $display("FAIL reset_rf_bus got=%h want=0", ex_to_rf_bus); end
    n_checks++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== 69'b0) begin
      n_fail++; $display("FAIL reset_sram got=%b/%h/%h/%h want=0", data_sram_en, data_sram_wen,
                         data_sram_addr, data_sram_wdata);
    end
    n_checks++;
    if ({stallreq_for_ex, ex_is_load} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got=%b%b want=00", stallreq_for_ex, ex_is_load);
    end
    rst = 1'b0;
    id_to_ex_bus = '0;
    step();
  endtask

  task automatic test_addu();
    id_to_ex_bus = mk(rtype(6'b100001, 5'd3), OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
                      1'b0, 32'h0040_0000, 32'h7FFF_FFFF, 32'h1);
    step();
    n_checks++;
    if (ex_to_rf_bus !== {1'b1, 5'd3, 32'h8000_0000}) begin
      n_fail++; $display("FAIL addu_rf_bus got=%h want=%h", ex_to_rf_bus, {1'b1, 5'd3, 32'h8000_0000});
    end
    n_checks++;
    if (data_sram_en !== 1'b0) begin n_fail++; $display("FAIL addu_sram_en got=%b want=0", data_sram_en); end
  endtask

  task automatic test_mem();
    id_to_ex_bus = mk(32'hAC22_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                      32'h0040_0000, 32'h0000_1000, 32'hDEAD_BEEF);
    step();
    n_checks++;
    if ({data_sram_en, data_sram_wen} !== 5'b1_1111) begin
      n_fail++; $display("FAIL sw_en_wen got=%b/%h want=1/f", data_sram_en, data_sram_wen);
    end
    n_checks++;
    if (data_sram_addr !== 32'h0000_0FFC) begin n_fail++; $display("FAIL sw_addr got=%h want=00000ffc", data_sram_addr); end
    n_checks++;
    if (data_sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got=%h want=deadbeef", data_sram_wdata); end
    n_checks++;
    if (ex_is_load !== 1'b0) begin n_fail++; $display("FAIL sw_is_load got=%b want=0", ex_is_load); end
    // lw with a single-byte write-enable field clear: read request only
    id_to_ex_bus = mk(32'h8C24_0010, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1,
                      32'h0040_0000, 32'h0000_2000, 32'h0);
    step();
    n_checks++;
    if ({ex_is_load, data_sram_en, data_sram_wen, data_sram_addr} !== {1'b1, 1'b1, 4'h0, 32'h0000_2010}) begin
      n_fail++; $display("FAIL lw_req got=%b%b/%h/%h want=11/0/00002010", ex_is_load, data_sram_en,
                         data_sram_wen, data_sram_addr);
    end
    // partial byte store still asserts every wen bit
    id_to_ex_bus = mk(32'hA022_0001, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'b0010, 1'b0, 5'd0, 1'b0,
                      32'h0040_0000, 32'h0000_0100, 32'h0000_00AB);
    step();
    n_checks++;
    if (data_sram_wen !== 4'hF) begin n_fail++; $display("FAIL sb_wen got=%h want=f", data_sram_wen); end
  endtask

  typedef struct packed {
    logic [11:0] alu;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v[14];
    v[0]  = '{12'h400, 3'b001, 4'b0001, 32'h0,         32'h0,         32'h5,         32'h7,         32'hFFFF_FFFE};
    v[1]  = '{12'h200, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h1,         32'h1};
    v[2]  = '{12'h100, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h1,         32'h0};
    v[3]  = '{12'h080, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    v[4]  = '{12'h040, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
    v[5]  = '{12'h020, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hA000_0000, 32'h0000_000B, 32'hA000_000B};
    v[6]  = '{12'h010, 3'b001, 4'b0001, 32'h0,         32'h0,         32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    v[7]  = '{12'h008, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h0,         32'h0000_00F1, 32'h0000_0F10};
    v[8]  = '{12'h004, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h0,         32'h8000_0000, 32'h0800_0000};
    v[9]  = '{12'h002, 3'b100, 4'b0001, 32'h0000_0100, 32'h0,         32'h0,         32'h8000_0000, 32'hF800_0000};
    v[10] = '{12'h001, 3'b000, 4'b1000, 32'h3C01_1234, 32'h0,         32'h0,         32'h0,         32'h1234_0000};
    v[11] = '{12'h800, 3'b010, 4'b0100, 32'h0C00_0000, 32'h0040_0010, 32'h0,         32'h0,         32'h0040_0018};
    v[12] = '{12'h020, 3'b001, 4'b1000, 32'h3402_8001, 32'h0,         32'h0001_0000, 32'h0,         32'h0001_8001};
    v[13] = '{12'h000, 3'b001, 4'b0001, 32'h0,         32'h0,         32'h1234_5678, 32'h1,         32'h0};
    for (int i = 0; i < 14; i++) begin
      id_to_ex_bus = mk(v[i].inst, v[i].alu, v[i].s1, v[i].s2, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
                        v[i].pc, v[i].d1, v[i].d2);
      step();
      n_checks++;
      if (ex_to_rf_bus[31:0] !== v[i].exp) begin
        n_fail++; $display("FAIL alu_vec%0d got=%h want=%h", i, ex_to_rf_bus[31:0], v[i].exp);
      end
    end
  endtask

  // Issues a divide, queues 'next_bus' behind it, returns the number of stalled cycles
  task automatic run_div(input logic [5:0] func, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [163:0] next_bus, output int cycles);
    id_to_ex_bus = mk(rtype(func, 5'd0), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'h0040_0020, d1, d2);
    step();
    id_to_ex_bus = next_bus;
    cycles = 0;
    while (stallreq_for_ex === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  function automatic logic [163:0] mf(input logic hi_sel, input logic [4:0] rd);
    return mk(rtype(hi_sel ? 6'b010000 : 6'b010010, rd), 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0,
              1'b1, rd, 1'b0, 32'h0040_0024, 32'h0, 32'h0);
  endfunction

  task automatic test_div();
    int cyc;
    run_div(6'b011010, 32'hFFFF_FFF9, 32'h2, mf(1'b0, 5'd8), cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL div_stall_cycles got=%0d want=33", cyc); end
    step();
    n_checks++;
    if (ex_to_rf_bus !== {1'b1, 5'd8, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL div_mflo got=%h want=%h", ex_to_rf_bus, {1'b1, 5'd8, 32'hFFFF_FFFD});
    end
    id_to_ex_bus = mf(1'b1, 5'd9);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_mfhi got=%h want=ffffffff", ex_to_rf_bus[31:0]); end
  endtask

  task automatic test_divu_zero();
    int cyc;
    run_div(6'b011011, 32'h0000_1234, 32'h0, mf(1'b0, 5'd8), cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL divu0_stall_cycles got=%0d want=33", cyc); end
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got=%h want=ffffffff", ex_to_rf_bus[31:0]); end
    id_to_ex_bus = mf(1'b1, 5'd9);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'h0000_1234) begin n_fail++; $display("FAIL divu0_hi got=%h want=00001234", ex_to_rf_bus[31:0]); end
  endtask

  task automatic test_flush();
    id_to_ex_bus = mk(rtype(6'b011010, 5'd0), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0,
                      1'b0, 32'h0040_0030, 32'd100, 32'd3);
    step();
    id_to_ex_bus = '0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (stallreq_for_ex !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got=%b want=1", stallreq_for_ex); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL flush_stallreq got=%b want=0", stallreq_for_ex); end
    n_checks++;
    if ({ex_to_mem_bus, ex_to_rf_bus, data_sram_en} !== 120'b0) begin
      n_fail++; $display("FAIL flush_outputs got=%h/%h/%b want=0", ex_to_mem_bus, ex_to_rf_bus, data_sram_en);
    end
    id_to_ex_bus = mf(1'b1, 5'd10);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'h0000_1234) begin n_fail++; $display("FAIL flush_hi_kept got=%h want=00001234", ex_to_rf_bus[31:0]); end
    id_to_ex_bus = mf(1'b0, 5'd11);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_lo_kept got=%h want=ffffffff", ex_to_rf_bus[31:0]); end
    n_checks++;
    if (stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL flush_no_restart got=%b want=0", stallreq_for_ex); end
  endtask

  task automatic test_bubble();
    id_to_ex_bus = mk(32'hAC22_0000, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                      32'h0040_0040, 32'h0000_3000, 32'h5555_AAAA);
    step();
    stall_drv = 6'b001111;
    id_to_ex_bus = mk(rtype(6'b100001, 5'd12), OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd12,
                      1'b0, 32'h0040_0044, 32'd40, 32'd2);
    step();
    n_checks++;
    if ({data_sram_en, data_sram_addr} !== {1'b1, 32'h0000_3000}) begin
      n_fail++; $display("FAIL hold_sw got=%b/%h want=1/00003000", data_sram_en, data_sram_addr);
    end
    stall_drv = 6'b000111;
    step();
    n_checks++;
    if ({data_sram_en, ex_to_rf_bus[37]} !== 2'b00) begin
      n_fail++; $display("FAIL bubble_en got=%b%b want=00", data_sram_en, ex_to_rf_bus[37]);
    end
    n_checks++;
    if (ex_to_mem_bus !== 81'b0) begin n_fail++; $display("FAIL bubble_mem_bus got=%h want=0", ex_to_mem_bus); end
    stall_drv = 6'b000000;
    step();
    n_checks++;
    if (ex_to_rf_bus !== {1'b1, 5'd12, 32'd42}) begin
      n_fail++; $display("FAIL bubble_resume got=%h want=%h", ex_to_rf_bus, {1'b1, 5'd12, 32'd42});
    end
  endtask

  task automatic test_mthi_mtlo();
    id_to_ex_bus = mk(rtype(6'b010001, 5'd0), 12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
                      1'b0, 32'h0040_0050, 32'hA5A5_0001, 32'h0);
    step();
    id_to_ex_bus = mf(1'b1, 5'd13);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL mthi_fwd got=%h want=a5a50001", ex_to_rf_bus[31:0]); end
    id_to_ex_bus = mk(rtype(6'b010011, 5'd0), 12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
                      1'b0, 32'h0040_0058, 32'h5A5A_0002, 32'h0);
    step();
    id_to_ex_bus = mf(1'b0, 5'd14);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'h5A5A_0002) begin n_fail++; $display("FAIL mtlo_fwd got=%h want=5a5a0002", ex_to_rf_bus[31:0]); end
  endtask

  task automatic test_mult();
    logic [31:0] exp_lo, exp_hi;
`ifdef EX_MULT_EN
    exp_lo = 32'hFFFF_FFFA;
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_lo = 32'h5A5A_0002;
    exp_hi = 32'hA5A5_0001;
`endif
    id_to_ex_bus = mk(rtype(6'b011000, 5'd0), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0,
                      1'b0, 32'h0040_0060, 32'hFFFF_FFFE, 32'd3);
    step();
    n_checks++;
    if (stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL mult_no_stall got=%b want=0", stallreq_for_ex); end
    id_to_ex_bus = mf(1'b0, 5'd15);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== exp_lo) begin n_fail++; $display("FAIL mult_lo got=%h want=%h", ex_to_rf_bus[31:0], exp_lo); end
    id_to_ex_bus = mf(1'b1, 5'd16);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== exp_hi) begin n_fail++; $display("FAIL mult_hi got=%h want=%h", ex_to_rf_bus[31:0], exp_hi); end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    logic [163:0] div2;
    div2 = mk(rtype(6'b011010, 5'd0), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
              32'h0040_0070, 32'd7, 32'hFFFF_FFFE);
    run_div(6'b011011, 32'd100, 32'd7, div2, cyc1);
    n_checks++;
    if (cyc1 !== 33) begin n_fail++; $display("FAIL b2b_first_cycles got=%0d want=33", cyc1); end
    step();
    id_to_ex_bus = mf(1'b0, 5'd17);
    cyc2 = 0;
    while (stallreq_for_ex === 1'b1 && cyc2 < 100) begin
      cyc2++;
      step();
    end
    n_checks++;
    if (cyc2 !== 33) begin n_fail++; $display("FAIL b2b_second_cycles got=%0d want=33", cyc2); end
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b_lo got=%h want=fffffffd", ex_to_rf_bus[31:0]); end
    id_to_ex_bus = mf(1'b1, 5'd18);
    step();
    n_checks++;
    if (ex_to_rf_bus[31:0] !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_hi got=%h want=00000001", ex_to_rf_bus[31:0]); end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    stall_drv    = 6'b0;
    id_to_ex_bus = '0;
    test_reset();
    test_addu();
    test_mem();
    test_alu();
    test_div();
    test_divu_zero();
    test_flush();
    test_bubble();
    test_mthi_mtlo();
    test_mult();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage. Consumes the decode stage's id_to_ex_bus.
- Registers the decode output and computes the ALU result.
- Drives the data SRAM request and forwards the result back to decode via ex_to_rf_bus.
- Owns the HI/LO registers and a 32-iteration restoring divider for div/divu; raises a stall request while the divider is busy.

Parameters:
- ID_TO_EX_WD, 164, width of id_to_ex_bus
- EX_TO_MEM_WD, 81, width of ex_to_mem_bus
- EX_TO_RF_WD, 38, width of ex_to_rf_bus

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of the EX register and divider
- stall  in  6  pipeline stall vector; Stop=1; bit2 = EX register, bit3 = MEM register
- id_to_ex_bus  in  164  {mem_op[163:159], pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], data1[63:32], data2[31:0]}
- ex_to_mem_bus  out  81  {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, forwarding to decode
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  divider busy; upstream must hold
- ex_is_load  out  1  EX holds a load (sel_rf_res=1), for load-use hazard detection

Behaviour:
- EX register update, in priority order:
  - rst or flush: load all zeros.
  - stall[2]=Stop and stall[3]=NoStop: load bubble (zeros).
  - stall[2]=NoStop: capture id_to_ex_bus.
  - Otherwise: hold.
- A zero register is a NOP: every enable output is 0.
- All outputs are combinational from the EX register plus HI/LO/divider state. Reset value of every output is 0.
- Operand src1 (one-hot sel_alu_src1):
  - bit0: data1
  - bit1: pc
  - bit2: {27'b0, inst[10:6]}
- Operand src2 (one-hot sel_alu_src2):
  - bit0: data2
  - bit1: sign-extended inst[15:0]
  - bit2: 32'd8
  - bit3: zero-extended inst[15:0]
- alu_op is one-hot, bit11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add and sub are mod 2^32; no overflow trap.
  - slt is signed and sltu is unsigned; both yield 0/1.
  - Shifts: src2 shifted by src1[4:0]; sra is arithmetic.
  - lui: {src2[15:0], 16'b0}.
  - alu_op all zero: result 0.
- Decoded from inst with opcode 0:
  - mfhi (func 010000) / mflo (func 010010): ex_result = HI / LO.
  - mthi (func 010001) / mtlo (func 010011): HI / LO <= data1 when the instruction leaves EX (stall[2]=NoStop).
- Memory request:
  - data_sram_en = data_ram_en.
  - data_sram_wen = {4{|data_ram_wen}}.
  - data_sram_addr = ALU result.
  - data_sram_wdata = data2.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY on div (func 011010) or divu (func 011011) in EX. Operand magnitudes are latched, counter=0, stallreq_for_ex=1.
  - BUSY: one restoring step per cycle. After the 32nd step -> DONE. stallreq_for_ex=1 for the whole of BUSY.
  - The instruction entering EX at cycle 0 sees stallreq_for_ex high for cycles 0..32. Cycle 33 is DONE with stallreq_for_ex=0.
  - DONE -> IDLE when stall[2]=NoStop. At that edge LO<=quotient and HI<=remainder.
  - Signed div: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: no trap and same latency. For divu, LO=32'hFFFF_FFFF and HI=dividend.
  - flush or rst in any state: -> IDLE, HI/LO unchanged, stallreq_for_ex=0 next cycle.
- HI/LO reset to 0.
- Same-cycle HI/LO writes: a DONE divide and mthi/mtlo cannot coexist in EX. When one instruction leaves while the next enters, the entering mfhi reads the updated HI in its EX cycle.
- ex_is_load = sel_rf_res.

Optional Feature:
- Macro: EX_MULT_EN.
- Defined: mult (func 011000) and multu (func 011001) compute a single-cycle 64-bit product. {HI,LO} <= product when the instruction leaves EX. No stall.
- Undefined: mult/multu behave as NOPs for HI/LO; all other behaviour is unchanged.

Test Plan:
- addu: data1=32'h7FFF_FFFF, data2=1 -> ex_to_rf_bus wdata 32'h8000_0000, rf_we=1, rf_waddr=rd.
- sw: base 32'h1000, imm 16'hFFFC, data2=32'hDEAD_BEEF -> data_sram_en=1, wen=4'hF, addr=32'h0FFC, wdata=32'hDEAD_BEEF.
- div: data1=-7, data2=2 -> stallreq_for_ex high for 33 cycles, then low. Next instruction mflo returns 32'hFFFF_FFFD; mfhi returns 32'hFFFF_FFFF.
- divu: data1=32'h1234, data2=0 -> LO=32'hFFFF_FFFF, HI=32'h1234 after 33 stall cycles.
- flush at BUSY cycle 10 of a divide -> stallreq_for_ex=0 next cycle; HI/LO keep their prior values; outputs zero.
- stall[2]=Stop, stall[3]=NoStop for one cycle -> next cycle EX is a bubble: data_sram_en=0, rf_we=0.
